// File: rtl/dcache_sa_wt_pkg.sv
// Shared definitions for the set-associative write-through data cache:
// controller state encoding and address-split width helpers.
package dcache_sa_wt_pkg;

    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_LOOKUP      = 3'd1;
    localparam logic [2:0] ST_REFILL_REQ  = 3'd2;
    localparam logic [2:0] ST_REFILL_WAIT = 3'd3;
    localparam logic [2:0] ST_WRITE_REQ   = 3'd4;
    localparam logic [2:0] ST_RESP        = 3'd5;

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    // Byte offset occupies the two low address bits.
    function automatic int tag_w(input int addr_w, input int sets);
        return addr_w - $clog2(sets) - 2;
    endfunction

endpackage

// File: rtl/dcache_sa_wt_way.sv
// One cache way: per-set valid/tag/data storage with an asynchronous read
// port and a byte-strobed write port; valid bits clear on reset or flush.
module dcache_sa_wt_way
    import dcache_sa_wt_pkg::*;
#(
    parameter int  DATA_W = 32,
    parameter int  SETS   = 4,
    parameter int  TAG_W  = 28,
    localparam int IDX_W  = $clog2(SETS),
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_flush,
    input  logic [IDX_W-1:0]  i_ridx,
    output logic              o_valid,
    output logic [TAG_W-1:0]  o_tag,
    output logic [DATA_W-1:0] o_data,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_widx,
    input  logic [TAG_W-1:0]  i_wtag,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [STRB_W-1:0] i_wstrb
);

    logic [SETS-1:0]   r_valid;
    logic [TAG_W-1:0]  r_tag  [SETS];
    logic [DATA_W-1:0] r_data [SETS];

    function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                      input logic [DATA_W-1:0] new_w,
                                                      input logic [STRB_W-1:0] strb);
        logic [DATA_W-1:0] m;
        m = old_w;
        for (int b = 0; b < STRB_W; b++)
            if (strb[b]) m[8*b +: 8] = new_w[8*b +: 8];
        return m;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n)
            r_valid <= '0;
        else if (i_flush)
            r_valid <= '0;
        else if (i_we)
            r_valid[i_widx] <= 1'b1;
    end

    // A refill drives all strobes, so the same path covers fills and store merges.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_tag[i_widx]  <= i_wtag;
            r_data[i_widx] <= merge_bytes(r_data[i_widx], i_wdata, i_wstrb);
        end
    end

    assign o_valid = r_valid[i_ridx];
    assign o_tag   = r_tag[i_ridx];
    assign o_data  = r_data[i_ridx];

endmodule

// File: rtl/dcache_sa_wt.sv
// Set-associative, write-through, no-write-allocate data cache with
// valid/ready request interfaces to the core and to data memory.
module dcache_sa_wt
    import dcache_sa_wt_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int SETS   = 4,
    parameter int WAYS   = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cpu_req_valid,
    output logic                cpu_req_ready,
    input  logic                cpu_req_write,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    input  logic [DATA_W/8-1:0] cpu_wstrb,
    output logic                cpu_resp_valid,
    output logic [DATA_W-1:0]   cpu_rdata,
    input  logic                flush,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_write,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                hit,
    output logic                miss
);

    localparam int IDX_W  = idx_w(SETS);
    localparam int TAG_W  = tag_w(ADDR_W, SETS);
    localparam int STRB_W = DATA_W / 8;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic [2:0]          r_state;
    logic [ADDR_W-3:0]   r_word;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_wstrb;
    logic                r_write;
    logic [DATA_W-1:0]   r_rdata;

    logic [IDX_W-1:0]    w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic [WAYS-1:0]     w_way_valid;
    logic [WAYS-1:0]     w_way_hit;
    logic [WAYS-1:0]     w_way_we;
    logic [TAG_W-1:0]    w_way_tag  [WAYS];
    logic [DATA_W-1:0]   w_way_data [WAYS];
    logic [WAYS-1:0]     w_victim_oh;
    logic [WAYS-1:0]     w_rr_oh;
    logic                w_found;
    logic                w_hit;
    logic [DATA_W-1:0]   w_hit_data;
    logic                w_lookup;
    logic                w_flush_now;
    logic                w_fill;
    logic                w_store_hit;
    logic                w_all_valid;
    logic [DATA_W-1:0]   w_way_wdata;
    logic [STRB_W-1:0]   w_way_wstrb;
    logic                w_unused;

    assign w_unused    = ^cpu_addr[1:0];
    assign w_idx       = r_word[IDX_W-1:0];
    assign w_tag       = r_word[ADDR_W-3:IDX_W];
    assign w_lookup    = (r_state == ST_LOOKUP);
    assign w_flush_now = (r_state == ST_IDLE) && flush;
    assign w_fill      = (r_state == ST_REFILL_WAIT) && mem_resp_valid;
    assign w_store_hit = w_lookup && r_write && w_hit;
    assign w_all_valid = &w_way_valid;
    assign w_way_wdata = w_fill ? mem_rdata : r_wdata;
    assign w_way_wstrb = w_fill ? {STRB_W{1'b1}} : r_wstrb;

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        dcache_sa_wt_way #(.DATA_W(DATA_W), .SETS(SETS), .TAG_W(TAG_W)) u_way (
            .clk     (clk),
            .reset_n (reset_n),
            .i_flush (w_flush_now),
            .i_ridx  (w_idx),
            .o_valid (w_way_valid[g]),
            .o_tag   (w_way_tag[g]),
            .o_data  (w_way_data[g]),
            .i_we    (w_way_we[g]),
            .i_widx  (w_idx),
            .i_wtag  (w_tag),
            .i_wdata (w_way_wdata),
            .i_wstrb (w_way_wstrb)
        );
        assign w_way_hit[g] = w_way_valid[g] && (w_way_tag[g] == w_tag);
        assign w_way_we[g]  = (w_store_hit && w_way_hit[g]) || (w_fill && w_victim_oh[g]);
    end

    // At most one way matches, so an OR-reduction acts as the way mux.
    always_comb begin
        w_hit_data = '0;
        for (int w = 0; w < WAYS; w++)
            if (w_way_hit[w]) w_hit_data = w_hit_data | w_way_data[w];
    end
    assign w_hit = |w_way_hit;

    always_comb begin
        w_victim_oh = '0;
        w_found     = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!w_way_valid[w] && !w_found) begin
                w_victim_oh[w] = 1'b1;
                w_found        = 1'b1;
            end
        end
        if (!w_found) w_victim_oh = w_rr_oh;
    end

    if (WAYS > 1) begin : g_rr
        logic [WAY_W-1:0] r_rr [SETS];

        // Pointer moves only when a valid line was actually evicted.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                for (int s = 0; s < SETS; s++) r_rr[s] <= '0;
            end else if (w_fill && w_all_valid) begin
                r_rr[w_idx] <= r_rr[w_idx] + 1'b1;
            end
        end

        always_comb begin
            w_rr_oh             = '0;
            w_rr_oh[r_rr[w_idx]] = 1'b1;
        end
    end else begin : g_dm
        assign w_rr_oh = '1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE:        if (cpu_req_valid && cpu_req_ready) r_state <= ST_LOOKUP;
                ST_LOOKUP:      if (r_write)    r_state <= ST_WRITE_REQ;
                                else if (w_hit) r_state <= ST_IDLE;
                                else            r_state <= ST_REFILL_REQ;
                ST_REFILL_REQ:  if (mem_req_ready) r_state <= ST_REFILL_WAIT;
                ST_REFILL_WAIT: if (mem_resp_valid) begin
                                    r_rdata <= mem_rdata;
                                    r_state <= ST_RESP;
                                end
                ST_WRITE_REQ:   if (mem_req_ready) r_state <= ST_RESP;
                ST_RESP:        r_state <= ST_IDLE;
                default:        r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (cpu_req_valid && cpu_req_ready) begin
            r_word  <= cpu_addr[ADDR_W-1:2];
            r_wdata <= cpu_wdata;
            r_wstrb <= cpu_wstrb;
            r_write <= cpu_req_write;
        end
    end

    assign cpu_req_ready  = (r_state == ST_IDLE) && !flush;
    assign cpu_resp_valid = (w_lookup && !r_write && w_hit) || (r_state == ST_RESP);
    assign cpu_rdata      = w_lookup ? w_hit_data : r_rdata;
    assign hit            = w_lookup && w_hit;
    assign miss           = w_lookup && !w_hit;

    assign mem_req_valid  = (r_state == ST_REFILL_REQ) || (r_state == ST_WRITE_REQ);
    assign mem_req_write  = (r_state == ST_WRITE_REQ);
    assign mem_addr       = {r_word, 2'b00};
    assign mem_wdata      = r_wdata;
    assign mem_wstrb      = r_wstrb;

endmodule
